// File: rtl/fetch_realign_buffer_if.sv
// fetch_realign_buffer_if: fetch-side and decode-side handshake bundle for the realign buffer
interface fetch_realign_buffer_if;
  logic [31:0] fetch_req_addr;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_word;
  logic        fetch_ready;
  logic        flush;
  logic [31:0] flush_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_compressed;
  logic        instr_ready;
  modport master (
    output fetch_valid, fetch_addr, fetch_word, flush, flush_pc, instr_ready,
    input  fetch_req_addr, fetch_ready, instr_valid, instr, instr_pc, instr_compressed
  );
  modport slave (
    input  fetch_valid, fetch_addr, fetch_word, flush, flush_pc, instr_ready,
    output fetch_req_addr, fetch_ready, instr_valid, instr, instr_pc, instr_compressed
  );
endinterface

// File: rtl/fetch_realign_buffer.sv
// fetch_realign_buffer: halfword queue that realigns fetch words into 16/32-bit instructions
module fetch_realign_buffer #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input logic CLK,
  input logic RST,
  fetch_realign_buffer_if.slave bus
);
  logic [3:0][15:0] hw, sh, hw_n;
  logic [2:0] count, count_n, rem;
  logic [1:0] pop, add;
  logic [31:0] head_pc, fetch_pc;
  logic drop_low, is_c, accept, consume;
  assign is_c = hw[0][1:0] != 2'b11;
  assign bus.instr_valid = is_c ? count >= 3'd1 : count >= 3'd2;
  assign bus.instr = is_c ? {16'h0, hw[0]} : {hw[1], hw[0]};
  assign bus.instr_compressed = is_c;
  assign bus.instr_pc = head_pc;
  assign bus.fetch_req_addr = fetch_pc;
  assign bus.fetch_ready = count <= 3'd2;
  assign accept = bus.fetch_valid && bus.fetch_ready && !bus.flush && bus.fetch_addr == fetch_pc;
  assign consume = bus.instr_valid && bus.instr_ready && !bus.flush;
  assign pop = consume ? (is_c ? 2'd1 : 2'd2) : 2'd0;
  assign add = accept ? (drop_low ? 2'd1 : 2'd2) : 2'd0;
  assign rem = count - {1'b0, pop};
  assign count_n = rem + {1'b0, add};
  assign sh = hw >> {pop, 4'b0000};
  always_comb begin
    for (int i = 0; i < 4; i++)
      hw_n[i] = (accept && 3'(i) == rem) ? (drop_low ? bus.fetch_word[31:16] : bus.fetch_word[15:0]) :
                (accept && !drop_low && 3'(i) == rem + 3'd1) ? bus.fetch_word[31:16] : sh[i];
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      hw <= '0;
      count <= '0;
      head_pc <= RESET_PC;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      drop_low <= RESET_PC[1];
    end else if (bus.flush) begin
      count <= '0;
      head_pc <= bus.flush_pc;
      fetch_pc <= {bus.flush_pc[31:2], 2'b00};
      drop_low <= bus.flush_pc[1];
    end else begin
      hw <= hw_n;
      count <= count_n;
      head_pc <= head_pc + {29'b0, pop, 1'b0};
      fetch_pc <= accept ? fetch_pc + 32'd4 : fetch_pc;
      drop_low <= accept ? 1'b0 : drop_low;
    end
  end
endmodule

// File: tb/tb_fetch_realign_buffer.sv
// tb_fetch_realign_buffer: directed checks of realignment, handshakes, flush and reset
module tb_fetch_realign_buffer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int compared = 0;
  int mismatched = 0;
  fetch_realign_buffer_if bus();
  fetch_realign_buffer dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk_instr(input string name, input logic [31:0] e_instr, input logic [31:0] e_pc, input logic e_c);
    compared++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== e_instr || bus.instr_pc !== e_pc || bus.instr_compressed !== e_c) begin
      mismatched++;
      $display("FAIL %s: got v=%b instr=%h pc=%h c=%b, want v=1 instr=%h pc=%h c=%b",
               name, bus.instr_valid, bus.instr, bus.instr_pc, bus.instr_compressed, e_instr, e_pc, e_c);
    end
  endtask
  task automatic chk_idle(input string name, input logic [31:0] e_pc, input logic [31:0] e_req, input logic e_rdy);
    compared++;
    if (bus.instr_valid !== 1'b0 || bus.instr_pc !== e_pc || bus.fetch_req_addr !== e_req || bus.fetch_ready !== e_rdy) begin
      mismatched++;
      $display("FAIL %s: got v=%b pc=%h req=%h rdy=%b, want v=0 pc=%h req=%h rdy=%b",
               name, bus.instr_valid, bus.instr_pc, bus.fetch_req_addr, bus.fetch_ready, e_pc, e_req, e_rdy);
    end
  endtask
  task automatic chk_fetch(input string name, input logic [31:0] e_req, input logic e_rdy);
    compared++;
    if (bus.fetch_req_addr !== e_req || bus.fetch_ready !== e_rdy) begin
      mismatched++;
      $display("FAIL %s: got req=%h rdy=%b, want req=%h rdy=%b", name, bus.fetch_req_addr, bus.fetch_ready, e_req, e_rdy);
    end
  endtask
  task automatic drive(input logic fv, input logic [31:0] fa, input logic [31:0] fw, input logic fl, input logic [31:0] fpc, input logic ir);
    bus.fetch_valid = fv;
    bus.fetch_addr = fa;
    bus.fetch_word = fw;
    bus.flush = fl;
    bus.flush_pc = fpc;
    bus.instr_ready = ir;
  endtask
  task automatic step;
    @(negedge CLK);
  endtask
  task automatic redirect(input logic [31:0] pc);
    drive(1'b0, 32'h0, 32'h0, 1'b1, pc, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic test_reset;
    RST = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    step();
    step();
    RST = 1'b0;
    chk_idle("reset_state", 32'h8000_0000, 32'h8000_0000, 1'b1);
  endtask
  task automatic test_32bit;
    drive(1'b1, 32'h8000_0000, 32'h00A0_0093, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_instr("w32_instr", 32'h00A0_0093, 32'h8000_0000, 1'b0);
    chk_fetch("w32_req_after_accept", 32'h8000_0004, 1'b1);
    step();
    chk_instr("w32_hold_no_ready", 32'h00A0_0093, 32'h8000_0000, 1'b0);
    bus.instr_ready = 1'b1;
    step();
    chk_idle("w32_after_consume", 32'h8000_0004, 32'h8000_0004, 1'b1);
  endtask
  task automatic test_compressed_pair;
    redirect(32'h8000_0000);
    drive(1'b1, 32'h8000_0000, 32'h4501_4501, 1'b0, 32'h0, 1'b1);
    step();
    bus.fetch_valid = 1'b0;
    chk_instr("cpair_first", 32'h0000_4501, 32'h8000_0000, 1'b1);
    step();
    chk_instr("cpair_second", 32'h0000_4501, 32'h8000_0002, 1'b1);
    step();
    chk_idle("cpair_empty", 32'h8000_0004, 32'h8000_0004, 1'b1);
  endtask
  task automatic test_straddle;
    redirect(32'h0000_0000);
    drive(1'b1, 32'h0, 32'h0093_4501, 1'b0, 32'h0, 1'b1);
    step();
    bus.fetch_valid = 1'b0;
    chk_instr("strad_c", 32'h0000_4501, 32'h0, 1'b1);
    step();
    chk_idle("strad_wait", 32'h2, 32'h4, 1'b1);
    drive(1'b1, 32'h4, 32'h0000_00A0, 1'b0, 32'h0, 1'b1);
    step();
    bus.fetch_valid = 1'b0;
    chk_instr("strad_32", 32'h00A0_0093, 32'h2, 1'b0);
    chk_fetch("strad_count3_not_ready", 32'h8, 1'b0);
    step();
    chk_instr("strad_tail", 32'h0000_0000, 32'h6, 1'b1);
    chk_fetch("strad_count1_ready", 32'h8, 1'b1);
  endtask
  task automatic test_flush;
    drive(1'b1, 32'h2000, 32'h4501_4501, 1'b1, 32'h1002, 1'b1);
    step();
    drive(1'b1, 32'h2000, 32'h4501_4501, 1'b0, 32'h0, 1'b1);
    chk_idle("flush_redirect", 32'h1002, 32'h1000, 1'b1);
    step();
    chk_idle("flush_stale_ignored", 32'h1002, 32'h1000, 1'b1);
    drive(1'b1, 32'h1000, 32'h4501_0001, 1'b0, 32'h0, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_instr("flush_upper_only", 32'h0000_4501, 32'h1002, 1'b1);
    step();
    chk_idle("flush_drained", 32'h1004, 32'h1004, 1'b1);
  endtask
  task automatic test_backpressure;
    logic [31:0] exp_i [4];
    exp_i = '{32'h4501, 32'h4505, 32'h4509, 32'h450D};
    drive(1'b1, 32'h1004, 32'h4505_4501, 1'b0, 32'h0, 1'b0);
    step();
    chk_instr("bp_first", 32'h4501, 32'h1004, 1'b1);
    chk_fetch("bp_count2_ready", 32'h1008, 1'b1);
    drive(1'b1, 32'h1008, 32'h450D_4509, 1'b0, 32'h0, 1'b0);
    step();
    chk_instr("bp_hold_full", 32'h4501, 32'h1004, 1'b1);
    chk_fetch("bp_count4_not_ready", 32'h100C, 1'b0);
    drive(1'b1, 32'h100C, 32'h4515_4511, 1'b0, 32'h0, 1'b0);
    step();
    chk_instr("bp_hold_refused", 32'h4501, 32'h1004, 1'b1);
    chk_fetch("bp_refused_word", 32'h100C, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_instr($sformatf("bp_release_%0d", i), exp_i[i], 32'h1004 + 32'(2 * i), 1'b1);
    end
    step();
    chk_idle("bp_drained", 32'h100C, 32'h100C, 1'b1);
  endtask
  task automatic test_flush_priority;
    drive(1'b1, 32'h100C, 32'h00A0_0093, 1'b0, 32'h0, 1'b0);
    step();
    chk_instr("prio_setup", 32'h00A0_0093, 32'h100C, 1'b0);
    drive(1'b1, 32'h1010, 32'h4501_4501, 1'b1, 32'h3000, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk_idle("prio_flush_wins", 32'h3000, 32'h3000, 1'b1);
    step();
    chk_idle("prio_nothing_appended", 32'h3000, 32'h3000, 1'b1);
  endtask
  task automatic test_wrap;
    redirect(32'hFFFF_FFFE);
    drive(1'b1, 32'hFFFF_FFFC, 32'h4501_0001, 1'b0, 32'h0, 1'b0);
    step();
    bus.fetch_valid = 1'b0;
    chk_instr("wrap_instr", 32'h0000_4501, 32'hFFFF_FFFE, 1'b1);
    chk_fetch("wrap_req", 32'h0, 1'b1);
    bus.instr_ready = 1'b1;
    step();
    chk_idle("wrap_pc", 32'h0, 32'h0, 1'b1);
  endtask
  task automatic test_reset_mid;
    drive(1'b1, 32'h0, 32'h4501_4501, 1'b0, 32'h0, 1'b0);
    step();
    chk_instr("rstmid_filled", 32'h4501, 32'h0, 1'b1);
    RST = 1'b1;
    drive(1'b1, 32'h4, 32'h4501_4501, 1'b1, 32'h5000, 1'b1);
    step();
    RST = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk_idle("rstmid_restored", 32'h8000_0000, 32'h8000_0000, 1'b1);
  endtask
  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_32bit();
    test_compressed_pair();
    test_straddle();
    test_flush();
    test_backpressure();
    test_flush_priority();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/fetch_realign_buffer.md
Name: fetch_realign_buffer

Overview:
- Sits between the instruction fetch port and the control unit; feeds the control unit's `instr` input.
- Accepts word-aligned 32-bit fetch words and extracts halfword-aligned instructions from them, both RV32C 16-bit and 32-bit.
- Presents one instruction per cycle to decode with a valid/ready handshake.
- Tracks the fetch request address and the instruction PC, and supports pipeline flush/redirect to any halfword-aligned target.

Parameters:
- RESET_PC, 32'h8000_0000, PC after reset; bit 1 may be set, bit 0 must be 0.

Ports:
- CLK  input  1  clock
- RST  input  1  reset
- fetch_req_addr  output  32  word-aligned address of next word to fetch
- fetch_valid  input  1  fetch_word/fetch_addr valid this cycle
- fetch_addr  input  32  word address of fetch_word
- fetch_word  input  32  fetched memory word, little-endian halfwords
- fetch_ready  output  1  buffer will accept a word this cycle
- flush  input  1  redirect request
- flush_pc  input  32  redirect target, halfword-aligned
- instr_valid  output  1  instr/instr_pc/instr_compressed valid
- instr  output  32  instruction to decode; compressed form is zero-extended {16'h0, hw}
- instr_pc  output  32  PC of instr
- instr_compressed  output  1  instr is a 16-bit encoding
- instr_ready  input  1  decode consumes instr this cycle

Behaviour:
- Reset: RST is synchronous and active-high on CLK. Reset gives count=0, instr_valid=0, instr_pc=RESET_PC, fetch_req_addr={RESET_PC[31:2],2'b00}, drop_low=RESET_PC[1].
- Storage: 4-halfword queue hw[0..3], hw[0] oldest, with a 3-bit count (0..4). Internal registers: head_pc (drives instr_pc), fetch_pc (drives fetch_req_addr), drop_low.
- fetch_ready = (count <= 2). Combinational from registered state only; independent of instr_ready.
- Accept occurs when fetch_valid && fetch_ready && !flush && fetch_addr == fetch_pc.
  - A word with fetch_valid=1 and fetch_addr != fetch_pc (a stale response after redirect) is dropped silently. No state changes.
  - On accept: fetch_pc += 4.
  - If drop_low=1: append only fetch_word[31:16] (+1 halfword) and clear drop_low.
  - Else: append fetch_word[15:0] then fetch_word[31:16] (+2 halfwords).
- Output decode, combinational from the queue:
  - Compressed: count>=1 && hw[0][1:0] != 2'b11. Then instr_valid=1, instr={16'h0,hw[0]}, instr_compressed=1.
  - 32-bit: count>=2 && hw[0][1:0] == 2'b11. Then instr_valid=1, instr={hw[1],hw[0]}, instr_compressed=0.
  - Otherwise instr_valid=0; instr holds the current queue contents (don't-care).
- Consume occurs when instr_valid && instr_ready && !flush. It pops 1 halfword (compressed) or 2 halfwords (32-bit), and head_pc += 2 or 4.
- Same-cycle consume and accept: pop first, then append behind the remaining entries. count_next = count - popped + appended, which never exceeds 4 given the fetch_ready rule.
- Flush has priority over accept and consume in the same cycle. Next cycle:
  - count=0, head_pc=flush_pc, fetch_pc={flush_pc[31:2],2'b00}, drop_low=flush_pc[1].
  - instr_valid=0 in the cycle after flush.
- No address wrap handling: PCs wrap modulo 2^32 naturally (32'hFFFF_FFFC + 4 = 0).
- Outputs are stable while instr_valid && !instr_ready. No internal state change other than accepting fetches.
- RST mid-operation discards the queue and restores reset values in the next cycle, regardless of flush/fetch inputs.
- Latency: fetch word accepted at edge N gives instr_valid at cycle N+1, provided that word completes an instruction.

Test Plan:
- Reset, RESET_PC=0x8000_0000; supply word 0x00A00093 at 0x8000_0000 → next cycle instr=0x00A00093, instr_pc=0x8000_0000, instr_compressed=0; after consume, fetch_req_addr=0x8000_0004.
- Word 0x45014501 (two c.li) at 0x8000_0000, instr_ready=1 → cycle 1 instr=0x00004501 @0x8000_0000; cycle 2 instr=0x00004501 @0x8000_0002; count returns to 0.
- Straddling instruction: word 0x00934501 at 0x0 then 0x000000A0 at 0x4 → compressed 0x4501 @0x0; then instr_valid=0 until the second word arrives; then instr=0x00A00093 @0x2 (count=3→1 after pop).
- Flush with flush_pc=0x1002 → fetch_req_addr=0x1000; word 0x45010001 at 0x1000 yields only instr=0x00004501 @0x1002. Stale word at 0x2000 in the flush cycle or the cycle after is ignored.
- Backpressure: instr_ready=0, stream compressed words → fetch_ready drops once count=3 and 4 halfwords are never exceeded; instr holds constant; release → 4 instrs at PCs +0,+2,+4,+6 in consecutive cycles.
- Flush, fetch_valid, and instr_ready all high in one cycle with count=2 → flush wins: count=0, head_pc=flush_pc, no pop or append visible.
